// File: rtl/dm_multihart.sv
// Multi-hart debug module: DMI register file toward the DTM, abstract-command FSM
// with per-command timeout, and a bus slave used by the harts' debug handler code.
module dm_multihart #(
    parameter int NUM_HART    = 4,
    parameter int DATA_COUNT  = 2,
    parameter int CMD_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    output logic [NUM_HART-1:0] interrupt,
    input  logic                dmi_valid,
    output logic                dmi_ready,
    input  logic                dmi_write,
    input  logic [6:0]          dmi_addr,
    input  logic [31:0]         dmi_wdata,
    output logic [31:0]         dmi_rdata,
    input  logic                bus_valid,
    output logic                bus_ready,
    input  logic                bus_write,
    input  logic [19:0]         bus_addr,
    input  logic [31:0]         bus_wdata,
    output logic [31:0]         bus_rdata
);
    localparam int CW = $clog2(CMD_TIMEOUT) + 1;
    localparam logic [19:0] A_HALTED    = 20'h100;
    localparam logic [19:0] A_RESUMING  = 20'h104;
    localparam logic [19:0] A_REQUEST   = 20'h108;
    localparam logic [19:0] A_EXCEPTION = 20'h10C;

    // Handshake on both ports: the master holds valid (and its payload) until the
    // cycle with valid&&ready; ready pulses one cycle after valid, then drops.

    typedef enum logic [1:0] {IDLE, PENDING, DONE} state_t;
    state_t state, state_next;

    logic [31:0]         data [DATA_COUNT];
    logic [NUM_HART-1:0] haltreq, halted, resumeack;
    logic [9:0]          hartsel;
    logic                dmactive;
    logic [2:0]          cmderr;
    logic [31:0]         req_word;
    logic [CW-1:0]       cnt;

    logic        dmi_wr, dmi_rd, bus_wr, dm_wr, cmd_wr, resume_wr, act_now, busy, viol;
    logic [9:0]  new_sel;
    logic [7:0]  cmd_type;
    logic        sel_valid, sel_halted, sel_ack, sel_haltreq, new_sel_valid, dmi_data_hit;
    logic [31:0] dmi_rd_mux, bus_rd_mux, post_word;
    logic [63:0] halted64;
    logic [2:0]  err_set;
    logic        post, req_clr;

    assign interrupt = haltreq;
    assign dmi_wr    = dmi_valid && dmi_ready && dmi_write;
    assign dmi_rd    = dmi_valid && dmi_ready && !dmi_write;
    assign bus_wr    = bus_valid && bus_ready && bus_write;
    assign dm_wr     = dmi_wr && (dmi_addr == 7'h10);
    assign cmd_wr    = dmi_wr && (dmi_addr == 7'h17);
    assign resume_wr = dm_wr && dmi_wdata[30] && dmi_wdata[0];
    assign new_sel   = dmi_wdata[25:16];
    assign cmd_type  = dmi_wdata[31:24];
    // A dmcontrol write that sets dmactive applies its other fields in the same cycle.
    assign act_now   = dm_wr ? dmi_wdata[0] : dmactive;
    assign busy      = (state != IDLE);
    assign viol      = cmd_wr || resume_wr || ((dmi_wr || dmi_rd) && dmi_data_hit);
    assign halted64  = 64'(halted);

    always_comb begin
        sel_valid     = 1'b0;
        sel_halted    = 1'b0;
        sel_ack       = 1'b0;
        sel_haltreq   = 1'b0;
        new_sel_valid = 1'b0;
        for (int i = 0; i < NUM_HART; i++) begin
            if (hartsel == 10'(i)) begin
                sel_valid   = 1'b1;
                sel_halted  = halted[i];
                sel_ack     = resumeack[i];
                sel_haltreq = haltreq[i];
            end
            if (new_sel == 10'(i)) new_sel_valid = 1'b1;
        end
    end

    always_comb begin
        dmi_data_hit = 1'b0;
        dmi_rd_mux   = '0;
        for (int k = 0; k < DATA_COUNT; k++) begin
            if (dmi_addr == 7'(4 + k)) begin
                dmi_data_hit = 1'b1;
                dmi_rd_mux   = data[k];
            end
        end
        case (dmi_addr)
            7'h10: dmi_rd_mux = {sel_haltreq, 5'b0, hartsel, 15'b0, dmactive};
            7'h11: dmi_rd_mux = {14'b0, sel_ack, sel_ack, 4'b0,
                                 sel_valid && !sel_halted, sel_valid && !sel_halted,
                                 sel_halted, sel_halted, 4'b0, 4'd2};
            7'h16: dmi_rd_mux = {3'b0, 5'd0, 11'b0, busy, 1'b0, cmderr, 4'b0, 4'(DATA_COUNT)};
            7'h40: dmi_rd_mux = halted64[31:0];
            default: ;
        endcase
    end

    always_comb begin
        bus_rd_mux = '0;
        for (int k = 0; k < DATA_COUNT; k++)
            if (bus_addr == 20'(12'h380 + 4 * k)) bus_rd_mux = data[k];
        if (bus_addr == A_REQUEST) bus_rd_mux = req_word;
    end

    always_comb begin
        state_next = state;
        post       = 1'b0;
        post_word  = '0;
        err_set    = 3'd0;
        req_clr    = 1'b0;
        if (busy && viol) err_set = 3'd1;
        case (state)
            IDLE: begin
                if (resume_wr) begin
                    if (new_sel_valid) begin
                        post      = 1'b1;
                        post_word = {1'b1, 3'd1, 12'd0, 16'(new_sel)};
                    end
                end else if (cmd_wr && cmderr == 3'd0) begin
                    if (cmd_type != 8'd0 && cmd_type != 8'd2)
                        err_set = 3'd2;
                    else if (!sel_valid || !sel_halted)
                        err_set = 3'd4;
                    else begin
                        post = 1'b1;
                        if (cmd_type == 8'd0)
                            post_word = {1'b1, dmi_wdata[16] ? 3'd3 : 3'd2, dmi_wdata[11:0], 16'(hartsel)};
                        else
                            post_word = {1'b1, dmi_wdata[16] ? 3'd5 : 3'd4, 9'd0, dmi_wdata[22:20], 16'(hartsel)};
                    end
                end
                if (post) state_next = PENDING;
            end
            PENDING: begin
                if (bus_wr && bus_addr == A_REQUEST)
                    state_next = DONE;
                else if (bus_wr && bus_addr == A_EXCEPTION) begin
                    state_next = DONE;
                    err_set    = 3'd3;
                end else if (bus_wr && bus_addr == A_RESUMING && req_word[30:28] == 3'd1)
                    state_next = DONE;
                else if (cnt == CW'(CMD_TIMEOUT - 1)) begin
                    state_next = DONE;
                    err_set    = 3'd3;
                end
                if (state_next == DONE) req_clr = 1'b1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!act_now) begin
            state_next = IDLE;
            post       = 1'b0;
            err_set    = 3'd0;
            req_clr    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmi_ready <= 1'b0;
            bus_ready <= 1'b0;
            dmi_rdata <= '0;
            bus_rdata <= '0;
            dmactive  <= 1'b0;
            haltreq   <= '0;
            hartsel   <= '0;
            cmderr    <= '0;
            halted    <= '0;
            resumeack <= '0;
            req_word  <= '0;
            cnt       <= '0;
            for (int k = 0; k < DATA_COUNT; k++) data[k] <= '0;
        end else begin
            dmi_ready <= dmi_valid && !dmi_ready;
            bus_ready <= bus_valid && !bus_ready;
            if (dmi_valid && !dmi_write && !dmi_ready) dmi_rdata <= dmi_rd_mux;
            if (bus_valid && !bus_write && !bus_ready) bus_rdata <= bus_rd_mux;
            if (dm_wr) dmactive <= dmi_wdata[0];

            if (!act_now) begin
                haltreq <= '0;
                hartsel <= '0;
                cmderr  <= '0;
            end else begin
                if (dm_wr) begin
                    hartsel <= new_sel;
                    for (int i = 0; i < NUM_HART; i++)
                        if (new_sel == 10'(i)) haltreq[i] <= dmi_wdata[31];
                end
                // First error sticks; cmderr is only cleared by write-one-to-clear.
                if (err_set != 3'd0 && cmderr == 3'd0)
                    cmderr <= err_set;
                else if (dmi_wr && dmi_addr == 7'h16)
                    cmderr <= cmderr & ~dmi_wdata[10:8];
            end

            for (int i = 0; i < NUM_HART; i++) begin
                if (post && post_word[30:28] == 3'd1 && new_sel == 10'(i)) resumeack[i] <= 1'b0;
                if (bus_wr && bus_addr == A_HALTED && bus_wdata == 32'(i)) halted[i] <= 1'b1;
                if (bus_wr && bus_addr == A_RESUMING && bus_wdata == 32'(i)) begin
                    halted[i]    <= 1'b0;
                    resumeack[i] <= 1'b1;
                end
            end

            for (int k = 0; k < DATA_COUNT; k++) begin
                if (dmi_wr && dmi_addr == 7'(4 + k) && !busy)
                    data[k] <= dmi_wdata;
                else if (bus_wr && bus_addr == 20'(12'h380 + 4 * k))
                    data[k] <= bus_wdata;
            end

            if (req_clr)   req_word <= '0;
            else if (post) req_word <= post_word;

            if (state == PENDING) cnt <= cnt + 1'b1;
            else                  cnt <= '0;
        end
    end
endmodule

// File: tb/tb_dm_multihart.sv
// Directed bench for dm_multihart: DMI/bus transfers with expected read data
// queued at stimulus time and compared when the DUT returns the read word.
module tb_dm_multihart;
    localparam int NUM_HART    = 4;
    localparam int DATA_COUNT  = 2;
    localparam int CMD_TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [NUM_HART-1:0] interrupt;
    logic                dmi_valid, dmi_ready, dmi_write;
    logic [6:0]          dmi_addr;
    logic [31:0]         dmi_wdata, dmi_rdata;
    logic                bus_valid, bus_ready, bus_write;
    logic [19:0]         bus_addr;
    logic [31:0]         bus_wdata, bus_rdata;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    dm_multihart #(
        .NUM_HART(NUM_HART), .DATA_COUNT(DATA_COUNT), .CMD_TIMEOUT(CMD_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .interrupt(interrupt),
        .dmi_valid(dmi_valid), .dmi_ready(dmi_ready), .dmi_write(dmi_write),
        .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic dmi_xfer(input logic wr, input logic [6:0] a, input logic [31:0] wd,
                            output logic [31:0] rd);
        int n;
        n = 0;
        @(negedge clk);
        dmi_valid = 1'b1; dmi_write = wr; dmi_addr = a; dmi_wdata = wd;
        @(posedge clk); #1;
        while (!dmi_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!dmi_ready) check("dmi_handshake", 32'(dmi_ready), 32'd1);
        rd = dmi_rdata;
        @(posedge clk); #1;
        dmi_valid = 1'b0;
    endtask

    task automatic bus_xfer(input logic wr, input logic [19:0] a, input logic [31:0] wd,
                            output logic [31:0] rd);
        int n;
        n = 0;
        @(negedge clk);
        bus_valid = 1'b1; bus_write = wr; bus_addr = a; bus_wdata = wd;
        @(posedge clk); #1;
        while (!bus_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus_ready) check("bus_handshake", 32'(bus_ready), 32'd1);
        rd = bus_rdata;
        @(posedge clk); #1;
        bus_valid = 1'b0;
    endtask

    task automatic dmi_wr(input logic [6:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        dmi_xfer(1'b1, a, wd, rd);
    endtask

    task automatic bus_wr(input logic [19:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        bus_xfer(1'b1, a, wd, rd);
    endtask

    // scoreboard: expected word queued with the request, popped on the response
    task automatic dmi_rd(input logic [6:0] a, input logic [31:0] e, input string tag);
        logic [31:0] rd;
        exp_q.push_back(e);
        dmi_xfer(1'b0, a, 32'd0, rd);
        check(tag, rd, exp_q.pop_front());
    endtask

    task automatic bus_rd(input logic [19:0] a, input logic [31:0] e, input string tag);
        logic [31:0] rd;
        exp_q.push_back(e);
        bus_xfer(1'b0, a, 32'd0, rd);
        check(tag, rd, exp_q.pop_front());
    endtask

    initial begin
        logic [31:0] d0, d1, rd;
        int          busy_polls, n;

        reset = 1'b1;
        dmi_valid = 1'b0; dmi_write = 1'b0; dmi_addr = '0; dmi_wdata = '0;
        bus_valid = 1'b0; bus_write = 1'b0; bus_addr = '0; bus_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_interrupt", 32'(interrupt), 32'd0);
        check("rst_dmi_ready", 32'(dmi_ready), 32'd0);
        check("rst_bus_ready", 32'(bus_ready), 32'd0);
        check("rst_dmi_rdata", dmi_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        dmi_rd(7'h11, 32'h0000_0C02, "dmstatus_reset");
        check("ready_drops", 32'(dmi_ready), 32'd0);
        dmi_rd(7'h16, 32'h0000_0002, "abstractcs_reset");

        // haltreq on hart 0, hart 0 reports halted
        dmi_wr(7'h10, 32'h8000_0001);
        check("interrupt_h0", 32'(interrupt), 32'h1);
        bus_wr(20'h100, 32'd0);
        dmi_rd(7'h40, 32'h1, "haltsum0_h0");
        dmi_rd(7'h11, 32'h0000_0302, "dmstatus_halted");
        dmi_rd(7'h10, 32'h8000_0001, "dmcontrol_rb");

        // data registers from both sides, plus unmapped addresses
        d0 = $urandom();
        d1 = $urandom();
        dmi_wr(7'h04, d0);
        dmi_rd(7'h04, d0, "data0_dmi");
        bus_rd(20'h380, d0, "data0_bus");
        bus_wr(20'h384, d1);
        dmi_rd(7'h05, d1, "data1_dmi");
        dmi_rd(7'h06, 32'd0, "dmi_unmapped");
        bus_rd(20'h388, 32'd0, "bus_unmapped");

        // register-write command answered through REQUEST
        dmi_wr(7'h17, 32'h0023_1008);
        bus_rd(20'h108, 32'hB008_0000, "req_regwrite");
        dmi_rd(7'h16, 32'h0000_1002, "busy_set");
        dmi_wr(7'h17, 32'h0023_1008);
        dmi_rd(7'h16, 32'h0000_1102, "busy_cmd_err1");
        bus_wr(20'h108, 32'd0);
        dmi_rd(7'h16, 32'h0000_1102, "done_still_busy");
        dmi_rd(7'h16, 32'h0000_0102, "busy_cleared");
        bus_rd(20'h108, 32'd0, "req_cleared");
        dmi_wr(7'h16, 32'h0000_0100);
        dmi_rd(7'h16, 32'h0000_0002, "cmderr_w1c");

        // command to a running hart
        dmi_wr(7'h10, 32'h0001_0001);
        check("interrupt_keep", 32'(interrupt), 32'h1);
        dmi_rd(7'h10, 32'h0001_0001, "dmcontrol_sel1");
        dmi_wr(7'h17, 32'h0022_1000);
        dmi_rd(7'h16, 32'h0000_0402, "cmd_running_err4");
        bus_rd(20'h108, 32'd0, "no_req_posted");
        dmi_wr(7'h16, 32'h0000_0700);

        // unsupported cmdtype
        dmi_wr(7'h10, 32'h8000_0001);
        dmi_wr(7'h17, 32'h0100_0000);
        dmi_rd(7'h16, 32'h0000_0202, "cmdtype_err2");
        dmi_wr(7'h16, 32'h0000_0700);

        // memory-write command left unanswered until the timeout
        dmi_wr(7'h17, 32'h0221_0000);
        bus_rd(20'h108, 32'hD002_0000, "req_memwrite");
        busy_polls = 0;
        n = 0;
        rd = 32'h0000_1000;
        while (rd[12] && n < 30) begin
            dmi_xfer(1'b0, 7'h16, 32'd0, rd);
            if (rd[12]) busy_polls++;
            n++;
        end
        check("timeout_err3", rd, 32'h0000_0302);
        check("timeout_not_early", 32'(busy_polls >= 6), 32'd1);
        bus_rd(20'h108, 32'd0, "timeout_req_clr");
        dmi_wr(7'h16, 32'h0000_0700);

        // resume of hart 2
        dmi_wr(7'h10, 32'h0002_0001);
        bus_wr(20'h100, 32'd2);
        dmi_rd(7'h40, 32'h5, "haltsum0_h0h2");
        dmi_wr(7'h10, 32'h4002_0001);
        dmi_rd(7'h11, 32'h0000_0302, "resume_pending");
        bus_rd(20'h108, 32'h9000_0002, "req_resume");
        bus_wr(20'h104, 32'd2);
        dmi_rd(7'h11, 32'h0003_0C02, "resumeack_h2");
        dmi_rd(7'h40, 32'h1, "haltsum0_after");
        dmi_rd(7'h16, 32'h0000_0002, "resume_done");

        // hartsel beyond NUM_HART
        dmi_wr(7'h10, 32'h8005_0001);
        check("interrupt_bad_sel", 32'(interrupt), 32'h1);
        dmi_rd(7'h11, 32'h0000_0002, "dmstatus_bad_sel");
        dmi_wr(7'h17, 32'h0022_0000);
        dmi_rd(7'h16, 32'h0000_0402, "cmd_bad_sel_err4");
        dmi_wr(7'h16, 32'h0000_0700);

        // dmactive dropped mid-command
        dmi_wr(7'h10, 32'h8000_0001);
        dmi_wr(7'h17, 32'h0022_0000);
        dmi_rd(7'h16, 32'h0000_1002, "busy_before_drop");
        dmi_wr(7'h10, 32'h0000_0000);
        check("interrupt_dropped", 32'(interrupt), 32'h0);
        dmi_rd(7'h16, 32'h0000_0002, "idle_after_drop");
        bus_rd(20'h108, 32'd0, "req_after_drop");
        dmi_rd(7'h10, 32'h0000_0000, "dmcontrol_dropped");
        dmi_rd(7'h04, d0, "data_kept");

        if (exp_q.size() != 0) check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
